// File: rtl/multi_cycle_pkg.sv
// Shared types and encodings for the multi-cycle RV64 subset controller.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_ADD,
    CLS_SUB
  } alu_cls_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0000;

  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_RS1    = 2'b01;
  localparam logic [1:0] A_OLDPC  = 2'b10;

  localparam logic [1:0] B_RS2    = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

endpackage

// File: rtl/multi_cycle_ctrl_alu_ctrl_dec.sv
// ALU operation decoder: maps instruction class and funct fields
// to an ALU control code plus a legality flag.
module alu_ctrl_dec
  import multi_cycle_pkg::*;
(
  input  alu_cls_e   i_cls,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_control,
  output logic       o_legal
);

  logic w_unused_f7;
  assign w_unused_f7 = ^{i_funct7[6], i_funct7[4:0]};

  always_comb begin
    o_alu_control = ALU_ADD;
    o_legal       = 1'b1;
    unique case (i_cls)
      CLS_R, CLS_I: begin
        unique case (i_funct3)
          3'b000: o_alu_control =
            (i_cls == CLS_R && i_funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b100: o_alu_control = ALU_XOR;
          3'b110: o_alu_control = ALU_OR;
          3'b111: o_alu_control = ALU_AND;
          default: o_legal = 1'b0;
        endcase
      end
      CLS_SUB: o_alu_control = ALU_SUB;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the shared-ALU RV64 subset datapath.
module multi_cycle_ctrl
  import multi_cycle_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          inst,
  input  logic                 alu_zero,
  input  logic                 alu_sign,
  input  logic                 mem_ready,
  output logic                 imem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_out_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_control,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [3:0]           state
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               r_state;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_instret;

  alu_cls_e   w_cls;
  logic [3:0] w_alu_ctl;
  logic       w_fn_legal;
  logic       w_br_legal;
  logic       w_br_taken;
  state_e     w_ill_state;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused;

  assign w_opcode    = inst[6:0];
  assign w_funct3    = inst[14:12];
  assign w_unused    = ^{inst[24:15], inst[11:7]};
  assign w_ill_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  always_comb begin
    w_cls = CLS_ADD;
    unique case (r_state)
      S_EXEC_R: w_cls = CLS_R;
      S_EXEC_I: w_cls = CLS_I;
      S_BRANCH: w_cls = CLS_SUB;
      default:  w_cls = CLS_ADD;
    endcase
  end

  alu_ctrl_dec u_dec (
    .i_cls         (w_cls),
    .i_funct3      (w_funct3),
    .i_funct7      (inst[31:25]),
    .o_alu_control (w_alu_ctl),
    .o_legal       (w_fn_legal)
  );

  always_comb begin
    w_br_legal = 1'b1;
    w_br_taken = 1'b0;
    unique case (1'b1)
      (w_funct3 == 3'b000): w_br_taken = alu_zero;
      (w_funct3 == 3'b001): w_br_taken = !alu_zero;
      (w_funct3 == 3'b100): w_br_taken = alu_sign;
      (w_funct3 == 3'b101): w_br_taken = !alu_sign;
      default:              w_br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      unique case (r_state)
        S_FETCH:
          if (mem_ready) r_state <= S_DECODE;
        S_DECODE:
          unique case (w_opcode)
            OP_R:         r_state <= S_EXEC_R;
            OP_I:         r_state <= S_EXEC_I;
            OP_LD, OP_SD: r_state <= S_MEM_ADDR;
            OP_BR:        r_state <= S_BRANCH;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= w_ill_state;
            end
          endcase
        S_EXEC_R, S_EXEC_I:
          if (w_fn_legal) begin
            r_state <= S_WB_ALU;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= w_ill_state;
          end
        S_MEM_ADDR:
          r_state <= (w_opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:
          if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR:
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + CNT_ONE;
          end
        S_WB_ALU, S_WB_MEM: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + CNT_ONE;
        end
        S_BRANCH:
          if (w_br_legal) begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + CNT_ONE;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= w_ill_state;
          end
        S_HALT:
          r_state <= S_HALT;
        default:
          r_state <= S_FETCH;
      endcase
    end
  end

  // Gated by reset so nothing leaks while the async reset is held.
  always_comb begin
    imem_req      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_out_write = 1'b0;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          imem_req  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_a = A_PC;
          alu_src_b = B_FOUR;
        end
        S_DECODE: begin
          alu_src_a     = A_OLDPC;
          alu_src_b     = B_IMM_SH;
          alu_out_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a     = A_RS1;
          alu_src_b     = B_RS2;
          alu_out_write = w_fn_legal;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_src_a     = A_RS1;
          alu_src_b     = B_IMM;
          alu_out_write = (r_state == S_MEM_ADDR) || w_fn_legal;
        end
        S_MEM_RD: mem_read  = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = A_RS1;
          alu_src_b = B_RS2;
          pc_write  = w_br_legal && w_br_taken;
          pc_src    = w_br_legal && w_br_taken;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign alu_control = w_alu_ctl;
  assign illegal     = r_illegal;
  assign instret     = r_instret;
  assign state       = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: vector table plus
// hand sequences for halt, reset-in-request and counter wrap.
module tb_multi_cycle_ctrl;
  import multi_cycle_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_XORI = 32'h0070C293;
  localparam logic [31:0] I_LD   = 32'h0080B203;
  localparam logic [31:0] I_SD   = 32'h0020B423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  // imem rd wr ir pcw pcs aow | a | b | alu | rw m2r
  localparam logic [16:0] C_F1  = 17'b1_0_0_1_1_0_0_00_01_0010_0_0;
  localparam logic [16:0] C_F0  = 17'b1_0_0_0_0_0_0_00_01_0010_0_0;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_1_10_11_0010_0_0;
  localparam logic [16:0] C_EXR = 17'b0_0_0_0_0_0_1_01_00_0010_0_0;
  localparam logic [16:0] C_EXS = 17'b0_0_0_0_0_0_1_01_00_0110_0_0;
  localparam logic [16:0] C_EXX = 17'b0_0_0_0_0_0_1_01_10_1001_0_0;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_1_01_10_0010_0_0;
  localparam logic [16:0] C_MR  = 17'b0_1_0_0_0_0_0_00_00_0010_0_0;
  localparam logic [16:0] C_MW  = 17'b0_0_1_0_0_0_0_00_00_0010_0_0;
  localparam logic [16:0] C_WBA = 17'b0_0_0_0_0_0_0_00_00_0010_1_0;
  localparam logic [16:0] C_WBM = 17'b0_0_0_0_0_0_0_00_00_0010_1_1;
  localparam logic [16:0] C_BRT = 17'b0_0_0_0_1_1_0_01_00_0110_0_0;
  localparam logic [16:0] C_BRN = 17'b0_0_0_0_0_0_0_01_00_0110_0_0;
  localparam logic [16:0] C_RST = 17'b0_0_0_0_0_0_0_00_00_0010_0_0;
  localparam logic [16:0] M_NOALU = 17'h1FFC3;

  typedef struct {
    logic [31:0] inst;
    logic        rdy;
    logic        z;
    logic        s;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_sign = 1'b0;

  logic        d1_imem_req, d1_mem_read, d1_mem_write, d1_ir_write;
  logic        d1_pc_write, d1_pc_src, d1_alu_out_write;
  logic [1:0]  d1_alu_src_a, d1_alu_src_b;
  logic [3:0]  d1_alu_control, d1_state;
  logic        d1_reg_write, d1_mem_to_reg, d1_illegal;
  logic [31:0] d1_instret;
  logic [16:0] d1_ctl;

  logic        d2_imem_req, d2_mem_read, d2_mem_write, d2_ir_write;
  logic        d2_pc_write, d2_pc_src, d2_alu_out_write;
  logic [1:0]  d2_alu_src_a, d2_alu_src_b;
  logic [3:0]  d2_alu_control, d2_state;
  logic        d2_reg_write, d2_mem_to_reg, d2_illegal;
  logic [3:0]  d2_instret;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  multi_cycle_ctrl u_dut (
    .clk(clk), .reset(reset), .inst(inst),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .mem_ready(mem_ready),
    .imem_req(d1_imem_req), .mem_read(d1_mem_read),
    .mem_write(d1_mem_write), .ir_write(d1_ir_write),
    .pc_write(d1_pc_write), .pc_src(d1_pc_src),
    .alu_out_write(d1_alu_out_write),
    .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
    .alu_control(d1_alu_control), .reg_write(d1_reg_write),
    .mem_to_reg(d1_mem_to_reg), .illegal(d1_illegal),
    .instret(d1_instret), .state(d1_state)
  );

  multi_cycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .inst(inst),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .mem_ready(mem_ready),
    .imem_req(d2_imem_req), .mem_read(d2_mem_read),
    .mem_write(d2_mem_write), .ir_write(d2_ir_write),
    .pc_write(d2_pc_write), .pc_src(d2_pc_src),
    .alu_out_write(d2_alu_out_write),
    .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .alu_control(d2_alu_control), .reg_write(d2_reg_write),
    .mem_to_reg(d2_mem_to_reg), .illegal(d2_illegal),
    .instret(d2_instret), .state(d2_state)
  );

  assign d1_ctl = {d1_imem_req, d1_mem_read, d1_mem_write,
                   d1_ir_write, d1_pc_write, d1_pc_src,
                   d1_alu_out_write, d1_alu_src_a, d1_alu_src_b,
                   d1_alu_control, d1_reg_write, d1_mem_to_reg};

  function automatic vec_t v(input logic [31:0] i,
                             input logic r, input logic z,
                             input logic s, input logic [3:0] st,
                             input logic [16:0] c,
                             input logic [31:0] n);
    vec_t t;
    t.inst = i; t.rdy = r; t.z = z; t.s = s;
    t.st = st; t.ctl = c; t.ret = n;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic r,
                      input logic z, input logic s);
    inst = i; mem_ready = r; alu_zero = z; alu_sign = s;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    tv.push_back(v(I_ADD, 1, 0, 0, S_FETCH,    C_F1,  0));
    tv.push_back(v(I_ADD, 1, 0, 0, S_DECODE,   C_DEC, 0));
    tv.push_back(v(I_ADD, 1, 0, 0, S_EXEC_R,   C_EXR, 0));
    tv.push_back(v(I_ADD, 1, 0, 0, S_WB_ALU,   C_WBA, 0));
    tv.push_back(v(I_LD,  1, 0, 0, S_FETCH,    C_F1,  1));
    tv.push_back(v(I_LD,  1, 0, 0, S_DECODE,   C_DEC, 1));
    tv.push_back(v(I_LD,  1, 0, 0, S_MEM_ADDR, C_MA,  1));
    tv.push_back(v(I_LD,  0, 0, 0, S_MEM_RD,   C_MR,  1));
    tv.push_back(v(I_LD,  0, 0, 0, S_MEM_RD,   C_MR,  1));
    tv.push_back(v(I_LD,  1, 0, 0, S_MEM_RD,   C_MR,  1));
    tv.push_back(v(I_LD,  0, 0, 0, S_WB_MEM,   C_WBM, 1));
    tv.push_back(v(I_SD,  0, 0, 0, S_FETCH,    C_F0,  2));
    tv.push_back(v(I_SD,  1, 0, 0, S_FETCH,    C_F1,  2));
    tv.push_back(v(I_SD,  0, 0, 0, S_DECODE,   C_DEC, 2));
    tv.push_back(v(I_SD,  0, 0, 0, S_MEM_ADDR, C_MA,  2));
    tv.push_back(v(I_SD,  1, 0, 0, S_MEM_WR,   C_MW,  2));
    tv.push_back(v(I_XORI, 1, 0, 0, S_FETCH,   C_F1,  3));
    tv.push_back(v(I_XORI, 1, 0, 0, S_DECODE,  C_DEC, 3));
    tv.push_back(v(I_XORI, 1, 0, 0, S_EXEC_I,  C_EXX, 3));
    tv.push_back(v(I_XORI, 1, 0, 0, S_WB_ALU,  C_WBA, 3));
    tv.push_back(v(I_BEQ, 1, 1, 0, S_FETCH,    C_F1,  4));
    tv.push_back(v(I_BEQ, 1, 1, 0, S_DECODE,   C_DEC, 4));
    tv.push_back(v(I_BEQ, 1, 1, 0, S_BRANCH,   C_BRT, 4));
    tv.push_back(v(I_BGE, 1, 0, 1, S_FETCH,    C_F1,  5));
    tv.push_back(v(I_BGE, 1, 0, 1, S_DECODE,   C_DEC, 5));
    tv.push_back(v(I_BGE, 1, 0, 1, S_BRANCH,   C_BRN, 5));
    tv.push_back(v(I_BNE, 1, 1, 0, S_FETCH,    C_F1,  6));
    tv.push_back(v(I_BNE, 1, 1, 0, S_DECODE,   C_DEC, 6));
    tv.push_back(v(I_BNE, 1, 1, 0, S_BRANCH,   C_BRN, 6));
    tv.push_back(v(I_SUB, 1, 0, 0, S_FETCH,    C_F1,  7));
    tv.push_back(v(I_SUB, 1, 0, 0, S_DECODE,   C_DEC, 7));
    tv.push_back(v(I_SUB, 1, 0, 0, S_EXEC_R,   C_EXS, 7));
    tv.push_back(v(I_SUB, 1, 0, 0, S_WB_ALU,   C_WBA, 7));
    tv.push_back(v(I_SUB, 0, 0, 0, S_FETCH,    C_F0,  8));

    // Reset held 3 cycles with mem_ready high
    step(I_ADD, 1, 0, 0);
    chk("rst.ctl", 32'(d1_ctl), 32'(C_RST));
    chk("rst.state", 32'(d1_state), 32'(S_FETCH));
    chk("rst.instret", d1_instret, 0);
    chk("rst.illegal", 32'(d1_illegal), 0);
    repeat (3) nxt();
    reset = 1'b0;

    foreach (tv[i]) begin
      step(tv[i].inst, tv[i].rdy, tv[i].z, tv[i].s);
      chk($sformatf("v%0d.state", i), 32'(d1_state), 32'(tv[i].st));
      chk($sformatf("v%0d.ctl", i), 32'(d1_ctl), 32'(tv[i].ctl));
      chk($sformatf("v%0d.instret", i), d1_instret, tv[i].ret);
      nxt();
    end

    // Illegal opcode parks in HALT
    step(I_BAD, 1, 0, 0);
    chk("ill.fetch", 32'(d1_state), 32'(S_FETCH));
    nxt();
    step(I_BAD, 1, 0, 0);
    chk("ill.decode", 32'(d1_state), 32'(S_DECODE));
    chk("ill.notyet", 32'(d1_illegal), 0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      step(I_BAD, 1, 0, 0);
      chk($sformatf("halt%0d.state", k), 32'(d1_state), 32'(S_HALT));
      chk($sformatf("halt%0d.ctl", k), 32'(d1_ctl & M_NOALU), 0);
      chk($sformatf("halt%0d.illegal", k), 32'(d1_illegal), 1);
      chk($sformatf("halt%0d.instret", k), d1_instret, 8);
      nxt();
    end
    reset = 1'b1;
    #1;
    chk("unhalt.state", 32'(d1_state), 32'(S_FETCH));
    chk("unhalt.illegal", 32'(d1_illegal), 0);
    chk("unhalt.instret", d1_instret, 0);
    nxt();
    nxt();
    reset = 1'b0;

    // Reset asserted mid-store with the request pending
    repeat (4) begin step(I_ADD, 1, 0, 0); nxt(); end
    repeat (3) begin step(I_SD, 1, 0, 0); nxt(); end
    step(I_SD, 0, 0, 0);
    chk("mwr.state", 32'(d1_state), 32'(S_MEM_WR));
    chk("mwr.write", 32'(d1_mem_write), 1);
    chk("mwr.instret", d1_instret, 1);
    #2 reset = 1'b1;
    #1;
    chk("mwr.rst.write", 32'(d1_mem_write), 0);
    chk("mwr.rst.state", 32'(d1_state), 32'(S_FETCH));
    chk("mwr.rst.instret", d1_instret, 0);
    nxt();
    reset = 1'b0;

    // Skip-mode illegals and 4-bit counter wrap
    step(I_BAD, 1, 0, 0); nxt();
    step(I_BAD, 1, 0, 0);
    chk("skip.decode", 32'(d2_state), 32'(S_DECODE));
    nxt();
    step(I_SLL, 1, 0, 0);
    chk("skip.state", 32'(d2_state), 32'(S_FETCH));
    chk("skip.illegal", 32'(d2_illegal), 1);
    chk("skip.instret", 32'(d2_instret), 0);
    nxt();
    step(I_SLL, 1, 0, 0); nxt();
    step(I_SLL, 1, 0, 0);
    chk("f3ill.exec", 32'(d2_state), 32'(S_EXEC_R));
    nxt();
    for (int k = 1; k <= 17; k++) begin
      step(I_BEQ, 1, 0, 0);
      chk($sformatf("wrap%0d.state", k), 32'(d2_state), 32'(S_FETCH));
      chk($sformatf("wrap%0d.instret", k), 32'(d2_instret),
          32'((k - 1) % 16));
      nxt();
      step(I_BEQ, 1, 0, 0); nxt();
      step(I_BEQ, 1, 0, 0); nxt();
    end
    step(I_BEQ, 0, 0, 0);
    chk("wrap.final", 32'(d2_instret), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control FSM for the RV64 subset datapath: add/sub/and/or/xor, addi/xori/ori/andi, ld, sd, beq/bne/blt/bge. It sequences a shared-ALU datapath through fetch, decode, execute, memory and writeback states. It drives every mux select, write enable and memory request, and waits on a single memory ready handshake. It also counts retired instructions and flags illegal opcodes.

## Interface
- `HALT_ON_ILLEGAL`, default 1: 1 means an illegal opcode parks the FSM in HALT; 0 means it is skipped as a NOP.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock.
- `reset` in 1: reset; asynchronous, active-high.
- `inst` in 32: instruction register contents; valid from DECODE onward.
- `alu_zero` in 1: ALU result == 0.
- `alu_sign` in 1: ALU result bit 63.
- `mem_ready` in 1: memory completes the current imem/dmem access this cycle.
- `imem_req` out 1: instruction fetch request.
- `mem_read`, `mem_write` out 1 each: dmem request.
- `ir_write` out 1: load IR and old-PC register.
- `pc_write` out 1: update PC.
- `pc_src` out 1: PC source; 0 = ALU result, 1 = ALU-out register.
- `alu_out_write` out 1: latch ALU result.
- `alu_src_a` out 2: 00 = PC, 01 = rs1, 10 = old PC.
- `alu_src_b` out 2: 00 = rs2, 01 = const 4, 10 = imm64, 11 = imm64<<1.
- `alu_control` out 4: 0010 = add, 0110 = sub, 1001 = xor, 0001 = or, 0000 = and.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: writeback source; 1 = dmem data.
- `illegal` out 1: sticky illegal-opcode flag.
- `instret` out CNT_WIDTH: retired-instruction count.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
- FETCH: `imem_req`=1.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, a=PC, b=4, add.
  - Go to DECODE. Otherwise stay in FETCH.
- DECODE: a=old PC, b=imm<<1, add, `alu_out_write`=1 (precomputes branch target). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - any other opcode → set `illegal`, then HALT if HALT_ON_ILLEGAL=1, else FETCH.
- EXEC_R: a=rs1, b=rs2, op from funct3/funct7; `alu_out_write`=1; → WB_ALU.
- EXEC_I: a=rs1, b=imm, op from funct3 (funct7 ignored); `alu_out_write`=1; → WB_ALU.
- Unsupported funct3 in R-type or I-type: treated as illegal (same as an illegal opcode).
- MEM_ADDR: a=rs1, b=imm, add, `alu_out_write`=1; → MEM_RD for ld, MEM_WR for sd.
- MEM_RD / MEM_WR: `mem_read` or `mem_write` held at 1 until `mem_ready`. Then:
  - MEM_RD → WB_MEM.
  - MEM_WR → FETCH; the sd retires.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0; → FETCH.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1; → FETCH.
- BRANCH: a=rs1, b=rs2, sub. Condition by funct3:
  - 000 beq: `alu_zero`
  - 001 bne: !`alu_zero`
  - 100 blt: `alu_sign`
  - 101 bge: !`alu_sign`
  - If taken: `pc_write`=1, `pc_src`=1. Always → FETCH.
  - Any other funct3 is illegal.
- HALT: all outputs 0 except `illegal`. The FSM leaves HALT only on reset.
- `instret` increments by 1 when entering FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH. It wraps modulo 2^CNT_WIDTH. Skipped illegals do not count.
- Unlisted outputs are 0 in every state; `alu_control` defaults to 0010.

## Timing
- Reset (async, any state, including mid-request): state=FETCH, `illegal`=0, `instret`=0. All control outputs are 0 while `reset`=1; `alu_control`=0010, `state`=FETCH encoding.
- The first `imem_req` is asserted in the first cycle after `reset` deasserts.
- Outputs are decoded combinationally from the registered state, plus `mem_ready` in FETCH/MEM_RD/MEM_WR and `alu_zero`/`alu_sign` in BRANCH.
- Cycles per instruction with zero wait (`mem_ready` high in the request cycle):
  - R-type / I-type: 4
  - ld: 5
  - sd: 4
  - branch: 3
  - Each wait cycle adds 1.
- Request handshake: a request stays asserted with stable selects until the cycle in which `mem_ready`=1. `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- `illegal` asserts in the cycle after the DECODE (or BRANCH/EXEC) cycle that detected it.

## Structure
- Package `multi_cycle_pkg` holds:
  - the state enum
  - opcode constants
  - ALU control codes
  - `alu_src_a` / `alu_src_b` encodings
- Sub-module `alu_ctrl_dec`: combinational mapping of (class R/I/add/sub, funct3, funct7) → `alu_control`, plus a legal flag.

## Test plan
- Reset held 3 cycles, release with `mem_ready`=1 and `inst`=add x3,x1,x2 → states FETCH, DECODE, EXEC_R, WB_ALU; `reg_write`=1 in cycle 4; `instret`=1.
- ld with `mem_ready` low for 2 cycles in MEM_RD → `mem_read` held 3 cycles; `mem_to_reg`=1 in WB_MEM; 7 cycles total.
- beq, `alu_zero`=1 → `pc_write`=1 with `pc_src`=1 in BRANCH. bge, `alu_sign`=1 → no `pc_write` in BRANCH.
- `inst` opcode 1111111 with HALT_ON_ILLEGAL=1 → HALT, `illegal`=1, `imem_req` never re-asserts. Then reset → FETCH, `illegal`=0.
- Assert `reset` in MEM_WR with `mem_ready`=0 → `mem_write` drops immediately; `instret` unchanged from its pre-reset value is not required (cleared to 0).
- CNT_WIDTH=4, retire 17 instructions → `instret`=1 (wrap).
